hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter STALL_CYCLES, default 1, legal range 1..7, bubbles inserted per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 rs1_addr_i / rs2_addr_i  input  ADDR_W  ID-stage source register addresses.
REQ-007 rs1_used_i / rs2_used_i  input  1  ID instruction actually reads rs1 / rs2.
REQ-008 ex_memread_i  input  1  EX-stage instruction is a load.
REQ-009 ex_rd_addr_i  input  ADDR_W  EX-stage destination address.
REQ-010 mem_busy_i  input  1  data memory not ready; the whole pipeline must hold.
REQ-011 branch_taken_i  input  1  branch resolved taken in ID.
REQ-012 pc_write_o  output  1  PC update enable.
REQ-013 stall_o  output  1  hold IF/ID register.
REQ-014 noop_o  output  1  force bubble into ID/EX.
REQ-015 flush_o  output  1  clear IF/ID (squash fetched instruction).
REQ-016 freeze_o  output  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-017 lu_cnt_o / frz_cnt_o  output  CNT_W  load-use bubble count / freeze-cycle count.

Function
REQ-018 hit SHALL be ex_memread_i & (ex_rd_addr_i != 0) & ((rs1_used_i & rs1_addr_i == ex_rd_addr_i) | (rs2_used_i & rs2_addr_i == ex_rd_addr_i)); an rd of x0 never hazards.
REQ-019 FSM states: IDLE, LU_STALL, MEM_WAIT; 3-bit down-counter rem.
REQ-020 Outputs SHALL be combinational from state and inputs (same-cycle response); idle values: pc_write_o=1, all others 0.
REQ-021 Priority each cycle: mem_busy_i > load-use (hit or LU_STALL) > branch_taken_i.
REQ-022 Any state, mem_busy_i=1: pc_write_o=0, stall_o=1, freeze_o=1, noop_o=0, flush_o=0; next state MEM_WAIT; rem held.
REQ-023 IDLE, hit=1, mem_busy_i=0: pc_write_o=0, stall_o=1, noop_o=1; if STALL_CYCLES>1 go LU_STALL with rem=STALL_CYCLES-1, else stay IDLE.
REQ-024 LU_STALL, mem_busy_i=0: pc_write_o=0, stall_o=1, noop_o=1; rem decrements; rem==1 returns to IDLE; hit ignored in this state.
REQ-025 MEM_WAIT, mem_busy_i=0: return to LU_STALL if rem!=0, else IDLE; outputs for that cycle as in the destination state (IDLE evaluates hit/branch).
REQ-026 IDLE, branch_taken_i=1, no hit, no busy: flush_o=1, pc_write_o=1; branch_taken_i SHALL be ignored whenever stall_o=1.
REQ-027 Total bubbles per hazard SHALL equal STALL_CYCLES exactly, independent of interleaved freeze cycles.

Reset
REQ-028 While rst_i=1: outputs forced to idle values; on the edge: state IDLE, rem=0, counters 0.
REQ-029 Reset mid-stall or mid-freeze SHALL abandon the sequence; first post-reset cycle evaluates fresh in IDLE.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: lu_cnt_o increments each cycle noop_o=1, frz_cnt_o each cycle freeze_o=1, both wrap at 2^CNT_W.
REQ-031 Macro undefined: no counter flops; lu_cnt_o and frz_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-032 STALL_CYCLES=1, ex_memread_i=1, ex_rd=5, rs1=5, rs1_used=1 for one cycle -> exactly one cycle pc_write_o=0, stall_o=1, noop_o=1, then idle.
REQ-033 Same with ex_rd=0, rs1=0 -> no stall; and rs2=5 with rs2_used_i=0 -> no stall.
REQ-034 STALL_CYCLES=3, hazard, then mem_busy_i=1 for 2 cycles during second bubble -> 3 noop cycles total, 2 freeze cycles between, lu_cnt_o=3, frz_cnt_o=2 (macro on).
REQ-035 hit and branch_taken_i same cycle -> flush_o=0, noop_o=1; branch alone next cycle -> flush_o=1, pc_write_o=1.
REQ-036 rst_i=1 during second of 3 bubbles -> outputs idle that cycle; after release, state IDLE, counters 0, no residual bubble.
REQ-037 Macro off, repeat REQ-034 -> identical control outputs, counters read 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, memory-busy freeze, and branch flush.
// Define HAZARD_PERF_CNT_EN to build the load-use bubble and freeze-cycle counters.
module hazard_unit #(
    parameter int ADDR_W       = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic              ex_memread_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    input  logic              mem_busy_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              stall_o,
    output logic              noop_o,
    output logic              flush_o,
    output logic              freeze_o,
    output logic [CNT_W-1:0]  lu_cnt_o,
    output logic [CNT_W-1:0]  frz_cnt_o
);

    localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] rem_reg, rem_next;

    logic [ADDR_W-1:0] rs_addr [2];
    logic [1:0]        rs_used;
    logic [1:0]        src_match;
    logic              hit;
    logic              lu_active;

    assign rs_addr[0] = rs1_addr_i;
    assign rs_addr[1] = rs2_addr_i;
    assign rs_used    = {rs2_used_i, rs1_used_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = rs_used[gi] && (rs_addr[gi] == ex_rd_addr_i);
        end
    endgenerate

    assign hit = ex_memread_i && (ex_rd_addr_i != '0) && (|src_match);

    // A freeze that interrupted a bubble sequence resumes it with the remaining count.
    assign lu_active = (state_reg == LU_STALL) || ((state_reg == MEM_WAIT) && (rem_reg != 3'd0));

    always_comb begin
        pc_write_o = 1'b1;
        stall_o    = 1'b0;
        noop_o     = 1'b0;
        flush_o    = 1'b0;
        freeze_o   = 1'b0;
        state_next = state_reg;
        rem_next   = rem_reg;

        if (rst_i) begin
            state_next = IDLE;
            rem_next   = 3'd0;
        end else if (mem_busy_i) begin
            pc_write_o = 1'b0;
            stall_o    = 1'b1;
            freeze_o   = 1'b1;
            state_next = MEM_WAIT;
        end else if (lu_active) begin
            pc_write_o = 1'b0;
            stall_o    = 1'b1;
            noop_o     = 1'b1;
            rem_next   = (rem_reg == 3'd0) ? 3'd0 : rem_reg - 3'd1;
            state_next = (rem_reg <= 3'd1) ? IDLE : LU_STALL;
        end else begin
            state_next = IDLE;
            if (hit) begin
                pc_write_o = 1'b0;
                stall_o    = 1'b1;
                noop_o     = 1'b1;
                if (STALL_CYCLES > 1) begin
                    state_next = LU_STALL;
                    rem_next   = REM_INIT;
                end
            end else if (branch_taken_i) begin
                flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            rem_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_reg, frz_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_reg  <= '0;
            frz_cnt_reg <= '0;
        end else begin
            if (noop_o) begin
                lu_cnt_reg <= lu_cnt_reg + 1'b1;
            end
            if (freeze_o) begin
                frz_cnt_reg <= frz_cnt_reg + 1'b1;
            end
        end
    end

    assign lu_cnt_o  = lu_cnt_reg;
    assign frz_cnt_o = frz_cnt_reg;
`else
    assign lu_cnt_o  = '0;
    assign frz_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver pushes hand-computed expectations,
// a monitor compares each cycle's outputs and counters against them.
module tb_hazard_unit;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic       sel;
        logic       rst;
        logic [4:0] ctl;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr, ex_rd_addr;
    logic              rs1_used, rs2_used, ex_memread, mem_busy, branch_taken;

    logic             pc_write [2];
    logic             stall    [2];
    logic             noop     [2];
    logic             flush    [2];
    logic             freeze   [2];
    logic [CNT_W-1:0] lu_cnt   [2];
    logic [CNT_W-1:0] frz_cnt  [2];

    exp_t  exp_q [$];
    string name_q [$];

    int compared   = 0;
    int mismatched = 0;

    hazard_unit #(.ADDR_W(ADDR_W), .STALL_CYCLES(1), .CNT_W(CNT_W)) dut_sc1 (
        .clk_i(clk), .rst_i(rst),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .ex_memread_i(ex_memread), .ex_rd_addr_i(ex_rd_addr),
        .mem_busy_i(mem_busy), .branch_taken_i(branch_taken),
        .pc_write_o(pc_write[0]), .stall_o(stall[0]), .noop_o(noop[0]),
        .flush_o(flush[0]), .freeze_o(freeze[0]),
        .lu_cnt_o(lu_cnt[0]), .frz_cnt_o(frz_cnt[0])
    );

    hazard_unit #(.ADDR_W(ADDR_W), .STALL_CYCLES(3), .CNT_W(CNT_W)) dut_sc3 (
        .clk_i(clk), .rst_i(rst),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .ex_memread_i(ex_memread), .ex_rd_addr_i(ex_rd_addr),
        .mem_busy_i(mem_busy), .branch_taken_i(branch_taken),
        .pc_write_o(pc_write[1]), .stall_o(stall[1]), .noop_o(noop[1]),
        .flush_o(flush[1]), .freeze_o(freeze[1]),
        .lu_cnt_o(lu_cnt[1]), .frz_cnt_o(frz_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; expected control bundle is {pc_write, stall, noop, flush, freeze}.
    task automatic v(input string nm, input logic sel, input logic r,
                     input logic mr, input int rd, input int r1, input logic u1,
                     input int r2, input logic u2, input logic busy, input logic br,
                     input logic [4:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        ex_memread   = mr;
        ex_rd_addr   = ADDR_W'(rd);
        rs1_addr     = ADDR_W'(r1);
        rs1_used     = u1;
        rs2_addr     = ADDR_W'(r2);
        rs2_used     = u2;
        mem_busy     = busy;
        branch_taken = br;
        e.sel = sel;
        e.rst = r;
        e.ctl = ctl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    initial begin
        exp_t        e;
        string       nm;
        int          d;
        logic [4:0]  act;
        logic [CNT_W-1:0] m_lu, m_frz, want_lu, want_frz;
        m_lu  = '0;
        m_frz = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                d  = int'(e.sel);
                act = {pc_write[d], stall[d], noop[d], flush[d], freeze[d]};
                compared++;
                if (act !== e.ctl) begin
                    mismatched++;
                    $display("FAIL %s: ctl {pc,stall,noop,flush,freeze} got %b expected %b", nm, act, e.ctl);
                end else begin
                    $display("ok   %s: dut=%0d ctl=%b lu=%0d frz=%0d", nm, d, act, lu_cnt[d], frz_cnt[d]);
                end
                if (e.rst) begin
                    m_lu  = '0;
                    m_frz = '0;
                end else begin
`ifdef HAZARD_PERF_CNT_EN
                    want_lu  = m_lu;
                    want_frz = m_frz;
`else
                    want_lu  = '0;
                    want_frz = '0;
`endif
                    compared++;
                    if (lu_cnt[d] !== want_lu || frz_cnt[d] !== want_frz) begin
                        mismatched++;
                        $display("FAIL %s_cnt: lu/frz got %0d/%0d expected %0d/%0d",
                                 nm, lu_cnt[d], frz_cnt[d], want_lu, want_frz);
                    end
                    m_lu  = m_lu + CNT_W'(e.ctl[2]);
                    m_frz = m_frz + CNT_W'(e.ctl[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ex_memread = 1'b0; ex_rd_addr = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        mem_busy = 1'b0; branch_taken = 1'b0;

        //     name            sel r  mr rd r1 u1 r2 u2 bz br  pc st np fl fz
        v("a_rst_hit",        0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 5'b10000);
        v("a_idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);
        v("a_lu_rs1",         0, 0, 1, 5, 5, 1, 0, 0, 0, 0, 5'b01100);
        v("a_after_lu",       0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 5'b10000);
        v("a_rd_x0",          0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5'b10000);
        v("a_rs2_unused",     0, 0, 1, 5, 3, 1, 5, 0, 0, 0, 5'b10000);
        v("a_lu_rs2",         0, 0, 1, 5, 3, 1, 5, 1, 0, 0, 5'b01100);
        v("a_not_load",       0, 0, 0, 5, 5, 1, 5, 1, 0, 0, 5'b10000);
        v("a_branch",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10010);
        v("a_hit_and_br",     0, 0, 1, 6, 6, 1, 0, 0, 0, 1, 5'b01100);
        v("a_br_next",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10010);
        v("a_busy_br",        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b01001);
        v("a_wait_to_br",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10010);
        v("a_busy_hit",       0, 0, 1, 4, 4, 1, 0, 0, 1, 0, 5'b01001);
        v("a_wait_to_hit",    0, 0, 1, 4, 4, 1, 0, 0, 0, 0, 5'b01100);
        v("a_idle2",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);

        v("b_rst",            1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);
        v("b_lu_1",           1, 0, 1, 7, 7, 1, 0, 0, 0, 0, 5'b01100);
        v("b_busy_1",         1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 5'b01001);
        v("b_busy_2",         1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 5'b01001);
        v("b_lu_2",           1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 5'b01100);
        v("b_lu_3",           1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 5'b01100);
        v("b_idle_cnt",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);
        v("b_lu_br_1",        1, 0, 1, 2, 2, 1, 0, 0, 0, 1, 5'b01100);
        v("b_lu_br_2",        1, 0, 1, 2, 2, 1, 0, 0, 0, 1, 5'b01100);
        v("b_lu_br_3",        1, 0, 0, 0, 2, 1, 0, 0, 0, 1, 5'b01100);
        v("b_br_after",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10010);
        v("b_lu_again",       1, 0, 1, 9, 0, 0, 9, 1, 0, 0, 5'b01100);
        v("b_rst_mid",        1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 5'b10000);
        v("b_post_rst",       1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 5'b10000);
        v("b_post_rst2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);
        v("b_busy_idle",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01001);
        v("b_release",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);
        v("b_final",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
